fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller between the instruction fetch path and a variable-latency instruction memory. It owns the fetch word address and issues memory requests over a req/ack handshake. It buffers returned instructions for the decode stage behind a valid/ready handshake. On a jump, branch or JR redirect it squashes buffered and in-flight fetches and restarts at the target.

## Interface
- ADDR_W, 30, word-address width; the byte address is {addr, 2'b00}
- RESET_ADDR, 30'h0, word address fetched first after reset
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request; held until accepted
- mem_addr  out  ADDR_W  word address of the current request; stable while mem_req=1
- mem_ack  in  1  request accepted; mem_rdata is valid in the same cycle
- mem_rdata  in  32  instruction word
- inst_valid  out  1  buffer head holds a valid instruction
- inst  out  32  instruction at the buffer head
- inst_addr  out  ADDR_W  word address of inst
- inst_ready  in  1  decode consumes the head when inst_valid=1
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_addr
- redirect_addr  in  ADDR_W  target word address
- busy  out  1  high when mem_req=1 or state=DROP

## Operation
- **Transfer rules**
  - A memory transfer occurs on any cycle with mem_req && mem_ack.
  - A pop occurs on any cycle with inst_valid && inst_ready.
- **Buffer**
  - FIFO of DEPTH entries. DEPTH=2 when prefetch is compiled in, 1 otherwise.
  - Each entry holds {addr, inst}. inst_valid = (count != 0).
- **Fetch pointer (fptr)**
  - Holds the next address to request. mem_addr = fptr.
  - On a kept transfer, fptr ← fptr+1, modulo 2^ADDR_W; 30'h3FFFFFFF wraps to 0.
- **States**
  - RESET → REQ: on the first rising edge after reset_n deasserts.
  - REQ (mem_req=1):
    - Transfer, no redirect: write the entry and advance fptr. Stay in REQ if the post-cycle count < DEPTH, else go to IDLE.
    - Redirect without transfer: go to DROP and latch the target into fptr_next.
    - Redirect with transfer: discard the data, set fptr ← redirect_addr, stay in REQ.
  - IDLE (mem_req=0):
    - Go to REQ when a pop makes room.
    - On redirect: set fptr ← redirect_addr and go to REQ.
  - DROP (mem_req=1, mem_addr = old fptr, held stable):
    - Waits for the abandoned request to complete.
    - On the transfer, discard the data, set fptr ← fptr_next, go to REQ.
    - A further redirect while in DROP overwrites fptr_next.
- **Redirect**
  - Clears the buffer on the same edge (count ← 0), overriding any simultaneous pop or write.
  - No instruction fetched from the old path is ever presented after the redirect cycle.
- **Simultaneous pop and write:** count is unchanged and order is preserved.
- **Reset mid-operation:** an outstanding request is abandoned and mem_req drops immediately. The memory must tolerate request withdrawal under reset.

## Timing
- **Reset values:**
  - mem_req=0, mem_addr=RESET_ADDR
  - inst_valid=0, inst=0, inst_addr=0
  - busy=0, count=0
- **After reset:** the first mem_req is in cycle 1 after the deasserting edge.
- **Latency:** ack in cycle N → inst_valid in cycle N+1. There is no combinational bypass from mem_rdata to inst.
- **Streaming:** with space available, mem_req stays high across consecutive transfers and mem_addr increments each transfer. The throughput is 1 instruction/cycle with a zero-wait memory.
- **Redirect:**
  - Redirect in cycle N with no outstanding request: mem_req at redirect_addr in cycle N+1.
  - Redirect while waiting: the DROP penalty lasts until the old ack arrives.
- All outputs are registered or decoded from state and fptr only. There is no combinational path from inputs to outputs.

## Configuration
- FETCH_PREFETCH_EN defined:
  - DEPTH=2.
  - Requests are issued whenever count < DEPTH, so a fetch overlaps decode stall.
- FETCH_PREFETCH_EN undefined:
  - DEPTH=1.
  - A request is issued only when the buffer is empty, so at most one instruction is in flight or buffered.
  - Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- Redirect and DROP behaviour are identical in both builds.

## Test plan
- Reset release, mem_ack tied 1, inst_ready=1 → mem_addr 0,1,2,3 on consecutive cycles; inst/inst_addr match one cycle later (prefetch build).
- mem_ack delayed 3 cycles → mem_addr and mem_req stable throughout; a single inst_valid pulse with inst_addr=0.
- inst_ready=0 → count saturates at DEPTH, mem_req=0 (IDLE). One pop → mem_req reasserts next cycle at the next address.
- Redirect to 0x100 while a request to 5 waits 2 more cycles → DROP keeps mem_addr=5 until ack. That data is never on inst. Then mem_addr=0x100 and inst_addr=0x100 is presented.
- Redirect coincident with mem_ack and a pop, buffer holding 1 → buffer empty next cycle, mem_addr=target, no stale inst_valid.
- RESET_ADDR=30'h3FFFFFFF → addresses 0x3FFFFFFF then 0x0; reset_n low mid-wait → mem_req=0 immediately, then restart at RESET_ADDR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the instruction fetch word address, issues requests to a
//   variable-latency instruction memory over a req/ack handshake and buffers
//   returned words for decode behind a valid/ready handshake. A redirect
//   squashes buffered and in-flight fetches and restarts at the target.
//
// Build option:
//   FETCH_PREFETCH_EN  defined   -> 2-entry buffer, fetch overlaps decode stall
//                      undefined -> 1-entry buffer, one instruction in flight
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   mem_req/mem_addr          request and word address (held until mem_ack)
//   mem_ack/mem_rdata         accept strobe, instruction word in same cycle
//   inst_valid/inst/inst_addr buffer head presented to decode
//   inst_ready                decode consumes the head
//   redirect/redirect_addr    one-cycle flush + restart target
//   busy                      request outstanding (includes DROP)
module fetch_sequencer #(
    parameter int                ADDR_W     = 30,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              busy
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_RESET, S_REQ, S_IDLE, S_DROP} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } entry_t;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      fptr_q, fptr_d;
    logic [ADDR_W-1:0]      fnext_q, fnext_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    entry_t [DEPTH-1:0]     ent_q, ent_d;
    logic                   mem_req_q, mem_req_d;

    logic                   xfer, pop, wr;
    logic [CNT_W-1:0]       widx;

    assign xfer = mem_req_q && mem_ack;
    assign pop  = (cnt_q != '0) && inst_ready;

    always_comb begin
        state_d = state_q;
        fptr_d  = fptr_q;
        fnext_d = fnext_q;
        cnt_d   = cnt_q;
        ent_d   = ent_q;
        wr      = 1'b0;
        widx    = '0;

        case (state_q)
            S_RESET: begin
                if (redirect) fptr_d = redirect_addr;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    if (xfer) begin
                        // Old-path data arrived with the redirect: drop it and
                        // request the target straight away.
                        fptr_d = redirect_addr;
                    end else begin
                        // Request must stay stable until acked; park the target.
                        fnext_d = redirect_addr;
                        state_d = S_DROP;
                    end
                end else if (xfer) begin
                    wr     = 1'b1;
                    fptr_d = fptr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (redirect) begin
                    fptr_d  = redirect_addr;
                    state_d = S_REQ;
                end else if (pop) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (xfer) begin
                    fptr_d  = redirect ? redirect_addr : fnext_q;
                    state_d = S_REQ;
                end else if (redirect) begin
                    fnext_d = redirect_addr;
                end
            end
            default: state_d = S_RESET;
        endcase

        // Shift FIFO: entry 0 is the head. Redirect wins over pop and write.
        if (redirect) begin
            cnt_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
            end
            widx = cnt_q - CNT_W'(pop);
            if (wr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == widx) begin
                        ent_d[i].addr = fptr_q;
                        ent_d[i].data = mem_rdata;
                    end
                end
            end
            cnt_d = cnt_q - CNT_W'(pop) + CNT_W'(wr);
        end

        // Stop requesting once the write fills the buffer.
        if (state_q == S_REQ && wr && cnt_d == CNT_W'(DEPTH)) state_d = S_IDLE;

        mem_req_d = (state_d == S_REQ) || (state_d == S_DROP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_RESET;
            fptr_q    <= RESET_ADDR;
            fnext_q   <= '0;
            cnt_q     <= '0;
            ent_q     <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fptr_q    <= fptr_d;
            fnext_q   <= fnext_d;
            cnt_q     <= cnt_d;
            ent_q     <= ent_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign busy       = mem_req_q;   // DROP always has a request outstanding
    assign mem_addr   = fptr_q;
    assign inst_valid = (cnt_q != '0);
    assign inst       = ent_q[0].data;
    assign inst_addr  = ent_q[0].addr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; expectations follow the build option
// FETCH_PREFETCH_EN where buffer depth changes the cycle pattern.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req, mem_ack, inst_valid, inst_ready, redirect, busy;
    logic [29:0] mem_addr, inst_addr, redirect_addr;
    logic [31:0] mem_rdata, inst;

    logic        req_b, ack_b, valid_b, ready_b, busy_b;
    logic [29:0] addr_b, iaddr_b;
    logic [31:0] rdata_b, inst_b;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [29:0] a);
        return {2'b11, a};
    endfunction

    assign mem_rdata = word(mem_addr);
    assign rdata_b   = word(addr_b);

    fetch_sequencer #(.ADDR_W(30), .RESET_ADDR(30'h0)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_addr(redirect_addr), .busy(busy)
    );

    fetch_sequencer #(.ADDR_W(30), .RESET_ADDR(30'h3FFFFFFF)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .mem_req(req_b), .mem_addr(addr_b), .mem_ack(ack_b), .mem_rdata(rdata_b),
        .inst_valid(valid_b), .inst(inst_b), .inst_addr(iaddr_b), .inst_ready(ready_b),
        .redirect(1'b0), .redirect_addr(30'h0), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        redirect_addr = '0; ack_b = 1'b0; ready_b = 1'b0;
        step; step;

        // reset values
        chk("rst_req",   64'(mem_req),    64'(0));
        chk("rst_addr",  64'(mem_addr),   64'(0));
        chk("rst_valid", 64'(inst_valid), 64'(0));
        chk("rst_inst",  64'(inst),       64'(0));
        chk("rst_iaddr", 64'(inst_addr),  64'(0));
        chk("rst_busy",  64'(busy),       64'(0));
        chk("rst_addr_b", 64'(addr_b),    64'(30'h3FFFFFFF));

        reset_n = 1'b1;
        step;
        chk("first_req",  64'(mem_req),  64'(1));
        chk("first_addr", 64'(mem_addr), 64'(0));

        // streaming with zero-wait memory
        mem_ack = 1'b1; inst_ready = 1'b1;
`ifdef FETCH_PREFETCH_EN
        for (int i = 0; i < 4; i++) begin
            chk("strm_req",  64'(mem_req),  64'(1));
            chk("strm_addr", 64'(mem_addr), 64'(i));
            if (i > 0) begin
                chk("strm_valid", 64'(inst_valid), 64'(1));
                chk("strm_iaddr", 64'(inst_addr),  64'(i - 1));
                chk("strm_inst",  64'(inst),       64'(word(30'(i - 1))));
            end
            step;
        end
        mem_ack = 1'b0;
        chk("strm_last_iaddr", 64'(inst_addr), 64'(3));
        step;
`else
        for (int i = 0; i < 4; i++) begin
            chk("strm_req",   64'(mem_req),    64'(1));
            chk("strm_addr",  64'(mem_addr),   64'(i));
            chk("strm_novld", 64'(inst_valid), 64'(0));
            step;
            chk("strm_idle",  64'(mem_req),    64'(0));
            chk("strm_valid", 64'(inst_valid), 64'(1));
            chk("strm_iaddr", 64'(inst_addr),  64'(i));
            chk("strm_inst",  64'(inst),       64'(word(30'(i))));
            step;
        end
        mem_ack = 1'b0;
`endif
        chk("strm_end_req",   64'(mem_req),    64'(1));
        chk("strm_end_addr",  64'(mem_addr),   64'(4));
        chk("strm_end_valid", 64'(inst_valid), 64'(0));

        // ack delayed 3 cycles: request held stable
        for (int k = 0; k < 3; k++) begin
            chk("wait_req",   64'(mem_req),    64'(1));
            chk("wait_addr",  64'(mem_addr),   64'(4));
            chk("wait_valid", 64'(inst_valid), 64'(0));
            step;
        end
        mem_ack = 1'b1;
        step;
        mem_ack = 1'b0;
        chk("wait_pulse",  64'(inst_valid), 64'(1));
        chk("wait_iaddr",  64'(inst_addr),  64'(4));
        chk("wait_inst",   64'(inst),       64'(word(30'd4)));
`ifdef FETCH_PREFETCH_EN
        chk("wait_pf_req", 64'(mem_req),    64'(1));
`else
        chk("wait_np_req", 64'(mem_req),    64'(0));
`endif
        step;
        chk("wait_pulse_end", 64'(inst_valid), 64'(0));
        chk("wait_next_req",  64'(mem_req),    64'(1));
        chk("wait_next_addr", 64'(mem_addr),   64'(5));

        // decode stall: buffer fills, requests stop
        inst_ready = 1'b0; mem_ack = 1'b1;
`ifdef FETCH_PREFETCH_EN
        step; step;
`else
        step;
`endif
        chk("full_req",   64'(mem_req),    64'(0));
        chk("full_busy",  64'(busy),       64'(0));
        chk("full_valid", 64'(inst_valid), 64'(1));
        chk("full_iaddr", 64'(inst_addr),  64'(5));
        step;
        chk("full_hold_req",   64'(mem_req),   64'(0));
        chk("full_hold_iaddr", 64'(inst_addr), 64'(5));
        inst_ready = 1'b1; mem_ack = 1'b0;
        step;
        chk("room_req", 64'(mem_req), 64'(1));
`ifdef FETCH_PREFETCH_EN
        chk("room_addr",  64'(mem_addr),  64'(7));
        chk("room_iaddr", 64'(inst_addr), 64'(6));
`else
        chk("room_addr",  64'(mem_addr),   64'(6));
        chk("room_valid", 64'(inst_valid), 64'(0));
`endif

        // reset while a request waits: request withdrawn immediately
        reset_n = 1'b0;
        #1;
        chk("midrst_req",   64'(mem_req),    64'(0));
        chk("midrst_busy",  64'(busy),       64'(0));
        chk("midrst_addr",  64'(mem_addr),   64'(0));
        chk("midrst_valid", 64'(inst_valid), 64'(0));
        step;
        reset_n = 1'b1;
        step;
        chk("restart_req",    64'(mem_req), 64'(1));
        chk("restart_addr",   64'(mem_addr), 64'(0));
        chk("restart_addr_b", 64'(addr_b),  64'(30'h3FFFFFFF));

        // redirect while waiting: DROP holds old address until ack
        inst_ready = 1'b1;
        redirect = 1'b1; redirect_addr = 30'h100;
        step;
        redirect = 1'b0;
        chk("drop_req",   64'(mem_req),    64'(1));
        chk("drop_addr",  64'(mem_addr),   64'(0));
        chk("drop_busy",  64'(busy),       64'(1));
        chk("drop_valid", 64'(inst_valid), 64'(0));
        step;
        chk("drop_addr2", 64'(mem_addr), 64'(0));
        mem_ack = 1'b1;
        step;
        chk("tgt_addr",  64'(mem_addr),   64'(30'h100));
        chk("tgt_novld", 64'(inst_valid), 64'(0));
        step;
        mem_ack = 1'b0;
        chk("tgt_valid", 64'(inst_valid), 64'(1));
        chk("tgt_iaddr", 64'(inst_addr),  64'(30'h100));
        chk("tgt_inst",  64'(inst),       64'(word(30'h100)));
        step;
        chk("tgt_after_valid", 64'(inst_valid), 64'(0));
        chk("tgt_after_addr",  64'(mem_addr),   64'(30'h101));

        // second redirect while in DROP replaces the parked target
        redirect = 1'b1; redirect_addr = 30'h300;
        step;
        chk("drop2_addr", 64'(mem_addr), 64'(30'h101));
        redirect_addr = 30'h200;
        step;
        redirect = 1'b0;
        chk("drop2_hold", 64'(mem_addr), 64'(30'h101));
        mem_ack = 1'b1;
        step;
        mem_ack = 1'b0;
        chk("ovr_req",   64'(mem_req),    64'(1));
        chk("ovr_addr",  64'(mem_addr),   64'(30'h200));
        chk("ovr_valid", 64'(inst_valid), 64'(0));

        // redirect coincident with ack and pop, one entry buffered
        inst_ready = 1'b0; mem_ack = 1'b1;
        step;
        chk("co_pre_valid", 64'(inst_valid), 64'(1));
        chk("co_pre_iaddr", 64'(inst_addr),  64'(30'h200));
        redirect = 1'b1; redirect_addr = 30'h50; inst_ready = 1'b1;
        step;
        redirect = 1'b0;
        chk("co_flush", 64'(inst_valid), 64'(0));
        chk("co_req",   64'(mem_req),    64'(1));
        chk("co_addr",  64'(mem_addr),   64'(30'h50));
        step;
        mem_ack = 1'b0;
        chk("co_valid", 64'(inst_valid), 64'(1));
        chk("co_iaddr", 64'(inst_addr),  64'(30'h50));
        chk("co_inst",  64'(inst),       64'(word(30'h50)));
        step;
        chk("co_drain", 64'(inst_valid), 64'(0));

        // address wrap from top of the word space
        chk("wrap_req0",  64'(req_b),  64'(1));
        chk("wrap_addr0", 64'(addr_b), 64'(30'h3FFFFFFF));
        ack_b = 1'b1; ready_b = 1'b1;
        step;
        chk("wrap_valid", 64'(valid_b), 64'(1));
        chk("wrap_iaddr", 64'(iaddr_b), 64'(30'h3FFFFFFF));
`ifdef FETCH_PREFETCH_EN
        chk("wrap_req1",  64'(req_b),  64'(1));
        chk("wrap_addr1", 64'(addr_b), 64'(0));
`else
        chk("wrap_idle",  64'(req_b),  64'(0));
        step;
        chk("wrap_req1",  64'(req_b),  64'(1));
        chk("wrap_addr1", 64'(addr_b), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
